// File: rtl/ps2_pkg.sv
// ps2_pkg: shared states, default timings, frame layout and command bytes for the PS/2 host link.
package ps2_pkg;
  localparam logic [2:0] S_IDLE = 3'd0, S_INHIBIT = 3'd1, S_REQ = 3'd2, S_SEND = 3'd3, S_ACK = 3'd4, S_WAIT_IDLE = 3'd5;
  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    INHIBIT   = S_INHIBIT,
    REQ       = S_REQ,
    SEND      = S_SEND,
    ACK       = S_ACK,
    WAIT_IDLE = S_WAIT_IDLE
  } state_t;
  localparam int INHIBIT_CYCLES_DEF = 6000;
  localparam int TIMEOUT_CYCLES_DEF = 1_000_000;
  localparam int FILTER_LEN_DEF = 8;
  localparam int FRAME_LEN = 11;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED, CMD_ENABLE = 8'hF4, CMD_RESET = 8'hFF, RSP_ACK = 8'hFA;
  // Start bit sits in bit 0 so the frame register alone drives the data line.
  function automatic logic [FRAME_LEN-1:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake plus open-drain PS/2 pin signals of the host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic tx_valid, tx_ready, busy, done_tick, err_tick;
  logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
  modport master (
    output tx_data, tx_valid, ps2c_in, ps2d_in,
    input  tx_ready, busy, done_tick, err_tick, ps2c_oe, ps2d_oe
  );
  modport slave (
    input  tx_data, tx_valid, ps2c_in, ps2d_in,
    output tx_ready, busy, done_tick, err_tick, ps2c_oe, ps2d_oe
  );
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizers for PS/2 clock/data, clock debounce and filtered-clock fall pulse.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic c_raw,
  input  logic d_raw,
  output logic c_filt,
  output logic d_sync,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] c_s, d_s;
  logic [CW-1:0] cnt;
  logic flip;
  // Filtered clock only moves after FILTER_LEN consecutive differing samples.
  assign flip = c_s[1] != c_filt && cnt == CW'(FILTER_LEN - 1);
  assign d_sync = d_s[1];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      c_s <= '1;
      d_s <= '1;
      cnt <= '0;
      c_filt <= 1'b1;
      fall <= 1'b0;
    end else begin
      c_s <= {c_s[0], c_raw};
      d_s <= {d_s[0], d_raw};
      cnt <= (c_s[1] == c_filt || flip) ? '0 : cnt + CW'(1);
      c_filt <= flip ? c_s[1] : c_filt;
      fall <= flip && c_filt;
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, start, data, parity, stop, ACK).
// Define PS2_TX_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog that aborts a stalled transfer.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
`ifdef PS2_TX_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
`endif
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input logic clk,
  input logic resetn,
  ps2_host_tx_if.slave bus
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  state_t state, state_n;
  logic [FRAME_LEN-1:0] frame;
  logic [3:0] bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic c_filt, d_sync, fall, accept, abort, done, err;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk(clk),
    .resetn(resetn),
    .c_raw(bus.ps2c_in),
    .d_raw(bus.ps2d_in),
    .c_filt(c_filt),
    .d_sync(d_sync),
    .fall(fall)
  );

  assign accept = bus.tx_valid && state == IDLE;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) wd_cnt <= '0;
    else if (accept) wd_cnt <= '0;
    else if (state != IDLE && wd_cnt != TW'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + TW'(1);
  assign abort = state != IDLE && wd_cnt == TW'(TIMEOUT_CYCLES);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    done = 1'b0;
    err = 1'b0;
    unique case (state)
      IDLE:      state_n = accept ? INHIBIT : IDLE;
      INHIBIT:   state_n = inh_cnt == IW'(INHIBIT_CYCLES - 1) ? REQ : INHIBIT;
      REQ:       state_n = SEND;
      SEND:      state_n = (fall && bit_cnt == 4'd9) ? ACK : SEND;
      ACK: if (fall) begin
        state_n = d_sync ? IDLE : WAIT_IDLE;
        err = d_sync;
      end
      WAIT_IDLE: if (c_filt && d_sync) begin
        state_n = IDLE;
        done = 1'b1;
      end
      default:   state_n = IDLE;
    endcase
    // A completed handshake beats a watchdog expiring on the same cycle.
    if (abort && !done) begin
      state_n = IDLE;
      err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      frame <= '1;
      bit_cnt <= '0;
      inh_cnt <= '0;
    end else begin
      if (accept) frame <= make_frame(bus.tx_data);
      else if (state == SEND && fall) frame <= {1'b1, frame[FRAME_LEN-1:1]};
      inh_cnt <= state == INHIBIT ? inh_cnt + IW'(1) : '0;
      bit_cnt <= state == SEND ? bit_cnt + 4'(fall) : '0;
    end

  assign bus.tx_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.done_tick = done;
  assign bus.err_tick = err;
  assign bus.ps2c_oe = (state == INHIBIT || state == REQ) && !abort;
  assign bus.ps2d_oe = (state == REQ || state == SEND || state == ACK) && !frame[0] && !abort;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model plus bit/tick scoreboards for ps2_host_tx.
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 100, HALF = 20, TO = 2000;
  logic clk = 1'b0, resetn = 1'b0;
  logic dev_c = 1'b1, dev_d = 1'b1;
  logic ack_mode = 1'b1, silent = 1'b0, tick_prev = 1'b0;
  int total = 0, bad = 0, cyc = 0, done_n = 0, err_n = 0, abort_n = 0;
  int abort_at = 0, glitch_at = 0, t_inh = 0, e = 0, n = 0;
  logic exp_bits[$];
  int exp_tick[$];

  ps2_host_tx_if bus();
  assign bus.ps2c_in = dev_c & ~bus.ps2c_oe;
  assign bus.ps2d_in = dev_d & ~bus.ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
`ifdef PS2_TX_TIMEOUT_EN
    .TIMEOUT_CYCLES(TO),
`endif
    .FILTER_LEN(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input logic par);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(par);
    exp_bits.push_back(1'b1);
  endtask

  task automatic send(input logic [7:0] b, output int edges);
    int k;
    bus.tx_data = b;
    bus.tx_valid = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.busy && edges < 50);
    bus.tx_valid = 1'b0;
    t_inh = cyc;
    chk("accept_busy", bus.busy, 1);
    chk("accept_c_oe", bus.ps2c_oe, 1);
    k = 0;
    while (bus.ps2c_oe && !bus.ps2d_oe && k < INH + 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("inhibit_len", k, INH);
    chk("req_c_oe", bus.ps2c_oe, 1);
    chk("req_d_oe", bus.ps2d_oe, 1);
    @(posedge clk);
    #1;
    chk("send_c_released", bus.ps2c_oe, 0);
    chk("send_start_bit", bus.ps2d_oe, 1);
  endtask

  task automatic wait_tick(input string name);
    int k = 0;
    while (!(bus.done_tick || bus.err_tick) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(name, k < 3000, 1);
  endtask

  // Tick scoreboard: every done/err pulse must match the oldest expected outcome (1=done, 2=err).
  always @(negedge clk) begin
    if (tick_prev) chk("ready_after_tick", {bus.tx_ready, bus.ps2c_oe, bus.ps2d_oe}, 3'b100);
    tick_prev = bus.done_tick | bus.err_tick;
    if (bus.done_tick || bus.err_tick) begin
      chk("tick_exclusive", bus.done_tick & bus.err_tick, 0);
      if (bus.done_tick) done_n++;
      else err_n++;
      chk("tick_pending", exp_tick.size() > 0, 1);
      if (exp_tick.size() > 0) chk("tick_kind", bus.done_tick ? 1 : 2, exp_tick.pop_front());
    end
  end

  // Device model: clocks the frame, checks each bit on the rising edge, then ACKs (or not).
  initial begin
    forever begin
      @(negedge clk);
      if (bus.ps2c_in && !bus.ps2d_in && !silent && resetn) begin
        repeat (30) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
          dev_c = 1'b0;
          repeat (HALF) @(negedge clk);
          dev_c = 1'b1;
          if (i == 11) dev_d = 1'b1;
          if (i <= 10) begin
            chk("bit_pending", exp_bits.size() > 0, 1);
            if (exp_bits.size() > 0) chk($sformatf("bit%0d", i), bus.ps2d_in, exp_bits.pop_front());
          end
          if (i == abort_at) begin
            abort_n++;
            exp_bits.delete();
            break;
          end
          if (i == 10) dev_d = !ack_mode;
          if (i == glitch_at) begin
            repeat (5) @(negedge clk);
            dev_c = 1'b0;
            repeat (3) @(negedge clk);
            dev_c = 1'b1;
            repeat (HALF - 8) @(negedge clk);
          end else repeat (HALF) @(negedge clk);
        end
        dev_d = 1'b1;
      end
    end
  end

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_c_oe", bus.ps2c_oe, 0);
    chk("rst_d_oe", bus.ps2d_oe, 0);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ticks", {bus.done_tick, bus.err_tick}, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    push_frame(CMD_ENABLE, 1'b0);
    exp_tick.push_back(1);
    send(CMD_ENABLE, e);
    chk("idle_accept_edges", e, 1);
    wait_tick("f4_tick");
    repeat (100) @(negedge clk);

    push_frame(CMD_SET_LEDS, 1'b1);
    exp_tick.push_back(1);
    send(CMD_SET_LEDS, e);
    wait_tick("ed_tick");
    push_frame(8'h02, 1'b0);
    exp_tick.push_back(1);
    send(8'h02, e);
    chk("b2b_accept_edges", e, 2);
    wait_tick("02_tick");
    repeat (100) @(negedge clk);

    ack_mode = 1'b0;
    push_frame(8'h00, 1'b1);
    exp_tick.push_back(2);
    send(8'h00, e);
    wait_tick("noack_tick");
    chk("noack_err", bus.err_tick, 1);
    repeat (100) @(negedge clk);
    ack_mode = 1'b1;

    abort_at = 4;
    push_frame(CMD_ENABLE, 1'b0);
    send(CMD_ENABLE, e);
    n = 0;
    while (abort_n == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_seen", abort_n, 1);
    chk("pre_rst_d_oe", bus.ps2d_oe, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_oe", {bus.ps2c_oe, bus.ps2d_oe}, 0);
    chk("async_rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    abort_at = 0;
    repeat (50) @(negedge clk);
    chk("abort_no_tick", {done_n[7:0], err_n[7:0]}, {8'd3, 8'd1});

    push_frame(CMD_RESET, 1'b1);
    exp_tick.push_back(1);
    send(CMD_RESET, e);
    wait_tick("ff_tick");
    repeat (100) @(negedge clk);

    glitch_at = 3;
    push_frame(8'hA5, 1'b1);
    exp_tick.push_back(1);
    send(8'hA5, e);
    repeat (150) @(negedge clk);
    bus.tx_data = 8'h3C;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    wait_tick("glitch_tick");
    glitch_at = 0;
    repeat (20) @(negedge clk);
    chk("ignored_not_queued", bus.busy, 0);

`ifdef PS2_TX_TIMEOUT_EN
    silent = 1'b1;
    exp_tick.push_back(2);
    send(CMD_RESET, e);
    wait_tick("silent_tick");
    chk("timeout_cycles", cyc - t_inh, TO);
    chk("timeout_oe", {bus.ps2c_oe, bus.ps2d_oe}, 0);
    repeat (20) @(negedge clk);
    silent = 1'b0;
    chk("err_count", err_n, 2);
`else
    chk("err_count", err_n, 1);
`endif

    repeat (20) @(negedge clk);
    chk("done_count", done_n, 5);
    chk("bits_left", exp_bits.size(), 0);
    chk("ticks_left", exp_tick.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
